// File: rtl/sdio_cia_cmd52_router.sv
// rtl/sdio_cia_cmd52_router.sv - CMD52 address decoder and access sequencer for the CCCR/FBR/CIS blocks
module sdio_cia_cmd52_router #(
    parameter int          NUM_FUNCS     = 1,
    parameter int          READ_LATENCY  = 1,
    parameter logic [16:0] CIS_LAST_ADDR = 17'h17FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cmd_stb,
    input  logic        i_cmd_write,
    input  logic        i_cmd_raw,
    input  logic [2:0]  i_cmd_func,
    input  logic [16:0] i_cmd_addr,
    input  logic [7:0]  i_cmd_data,
    output logic        o_cmd_busy,
    output logic        o_cmd_done,
    output logic        o_cmd_err,
    output logic [7:0]  o_cmd_data,
    output logic        o_cccr_activate,
    output logic [6:0]  o_fbr_activate,
    output logic        o_cis_activate,
    output logic        o_write_flag,
    output logic [16:0] o_address,
    output logic        o_data_stb,
    output logic [7:0]  o_data_out,
    input  logic [7:0]  i_cccr_data,
    input  logic [55:0] i_fbr_data,
    input  logic [7:0]  i_cis_data
);

    localparam logic [16:0] CIS_BASE  = 17'h01000;
    localparam logic [1:0]  LAST_WAIT = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_write;
    logic        r_raw;
    logic [2:0]  r_func;
    logic [16:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_sel_cccr;
    logic [6:0]  r_sel_fbr;
    logic        r_sel_cis;
    logic        r_err;
    logic [16:0] r_tgt_addr;
    logic [1:0]  r_wait_cnt;
    logic [7:0]  r_cmd_data;

    logic        w_dec_cccr;
    logic        w_dec_fbr_any;
    logic [6:0]  w_dec_fbr;
    logic        w_dec_cis;
    logic        w_dec_err;
    logic [16:0] w_dec_addr;
    logic [7:0]  w_rd_byte;
    logic        w_wait_last;
    logic        w_active;

    // Address decode of the latched request; only function 0 reaches the CIA.
    always_comb begin
        w_dec_cccr    = (r_func == 3'd0) && (r_addr[16:8] == 9'd0);
        w_dec_fbr_any = (r_func == 3'd0) && (r_addr[16:12] == 5'd0) &&
                        (r_addr[11:8] != 4'd0) && (r_addr[11:8] <= 4'(NUM_FUNCS));
        for (int i = 0; i < 7; i++) begin
            w_dec_fbr[i] = w_dec_fbr_any && (r_addr[11:8] == 4'(i + 1));
        end
        w_dec_cis  = (r_func == 3'd0) && (r_addr >= CIS_BASE) && (r_addr <= CIS_LAST_ADDR);
        w_dec_err  = !(w_dec_cccr || w_dec_fbr_any || w_dec_cis);
        w_dec_addr = w_dec_cis ? (r_addr - CIS_BASE) : {9'd0, r_addr[7:0]};
    end

    // Read-data mux steered by the registered target select.
    always_comb begin
        w_rd_byte = 8'h00;
        if (r_sel_cccr) begin
            w_rd_byte = i_cccr_data;
        end
        if (r_sel_cis) begin
            w_rd_byte = i_cis_data;
        end
        for (int i = 0; i < 7; i++) begin
            if (r_sel_fbr[i]) begin
                w_rd_byte = i_fbr_data[i*8 +: 8];
            end
        end
    end

    assign w_wait_last = (r_wait_cnt == LAST_WAIT);
    assign w_active    = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_WAIT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-derived target bus outputs.
    always_comb begin
        w_next          = r_state;
        o_cmd_busy      = (r_state != S_IDLE);
        o_cmd_done      = 1'b0;
        o_cmd_err       = 1'b0;
        o_cccr_activate = w_active && r_sel_cccr;
        o_fbr_activate  = w_active ? r_sel_fbr : 7'd0;
        o_cis_activate  = w_active && r_sel_cis;
        o_write_flag    = 1'b0;
        o_data_stb      = 1'b0;
        o_data_out      = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_stb) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_dec_err) begin
                    w_next = S_DONE;
                end else if (r_write) begin
                    w_next = S_WRITE;
                end else begin
                    w_next = S_READ;
                end
            end
            S_WRITE: begin
                o_data_stb   = 1'b1;
                o_write_flag = 1'b1;
                o_data_out   = r_wdata;
                w_next       = r_raw ? S_READ : S_DONE;
            end
            S_READ: begin
                o_data_stb = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (w_wait_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_cmd_done = 1'b1;
                o_cmd_err  = r_err;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch, target select, wait counter and response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write    <= 1'b0;
            r_raw      <= 1'b0;
            r_func     <= 3'd0;
            r_addr     <= 17'd0;
            r_wdata    <= 8'h00;
            r_sel_cccr <= 1'b0;
            r_sel_fbr  <= 7'd0;
            r_sel_cis  <= 1'b0;
            r_err      <= 1'b0;
            r_tgt_addr <= 17'd0;
            r_wait_cnt <= 2'd0;
            r_cmd_data <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_stb) begin
                        r_write <= i_cmd_write;
                        r_raw   <= i_cmd_write & i_cmd_raw;
                        r_func  <= i_cmd_func;
                        r_addr  <= i_cmd_addr;
                        r_wdata <= i_cmd_data;
                    end
                end
                S_DECODE: begin
                    r_sel_cccr <= w_dec_cccr;
                    r_sel_fbr  <= w_dec_fbr;
                    r_sel_cis  <= w_dec_cis;
                    r_err      <= w_dec_err;
                    r_tgt_addr <= w_dec_err ? 17'd0 : w_dec_addr;
                    if (w_dec_err) begin
                        r_cmd_data <= 8'h00;
                    end
                end
                S_WRITE: begin
                    if (!r_raw) begin
                        r_cmd_data <= r_wdata;
                    end
                end
                S_READ: begin
                    r_wait_cnt <= 2'd0;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 2'd1;
                    if (w_wait_last) begin
                        r_cmd_data <= w_rd_byte;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_address  = r_tgt_addr;
    assign o_cmd_data = r_cmd_data;

endmodule

// File: tb/tb_sdio_cia_cmd52_router.sv
// tb/tb_sdio_cia_cmd52_router.sv - scoreboard bench for the CMD52 router
module tb_sdio_cia_cmd52_router;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_checks = 0;
    int n_fail   = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_stb = 1'b0;
    logic        cmd_write = 1'b0;
    logic        cmd_raw = 1'b0;
    logic [2:0]  cmd_func = 3'd0;
    logic [16:0] cmd_addr = 17'd0;
    logic [7:0]  cmd_data = 8'h00;
    logic [7:0]  cccr_data = 8'h00;
    logic [55:0] fbr_data = 56'd0;
    logic [7:0]  cis_data = 8'h00;

    logic        busy_a, done_a, err_a, cccr_a, cis_a, wf_a, stb_a;
    logic [7:0]  cdata_a, dout_a;
    logic [6:0]  fbr_a;
    logic [16:0] addr_a;
    logic        busy_b, done_b, err_b, cccr_b, cis_b, wf_b, stb_b;
    logic [7:0]  cdata_b, dout_b;
    logic [6:0]  fbr_b;
    logic [16:0] addr_b;

    always #5 clk = ~clk;

    sdio_cia_cmd52_router #(.NUM_FUNCS(1), .READ_LATENCY(1), .CIS_LAST_ADDR(17'h17FFF)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_stb(cmd_stb), .i_cmd_write(cmd_write), .i_cmd_raw(cmd_raw),
        .i_cmd_func(cmd_func), .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
        .o_cmd_busy(busy_a), .o_cmd_done(done_a), .o_cmd_err(err_a), .o_cmd_data(cdata_a),
        .o_cccr_activate(cccr_a), .o_fbr_activate(fbr_a), .o_cis_activate(cis_a),
        .o_write_flag(wf_a), .o_address(addr_a), .o_data_stb(stb_a), .o_data_out(dout_a),
        .i_cccr_data(cccr_data), .i_fbr_data(fbr_data), .i_cis_data(cis_data)
    );

    sdio_cia_cmd52_router #(.NUM_FUNCS(2), .READ_LATENCY(3), .CIS_LAST_ADDR(17'h17FFF)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_stb(cmd_stb), .i_cmd_write(cmd_write), .i_cmd_raw(cmd_raw),
        .i_cmd_func(cmd_func), .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
        .o_cmd_busy(busy_b), .o_cmd_done(done_b), .o_cmd_err(err_b), .o_cmd_data(cdata_b),
        .o_cccr_activate(cccr_b), .o_fbr_activate(fbr_b), .o_cis_activate(cis_b),
        .o_write_flag(wf_b), .o_address(addr_b), .o_data_stb(stb_b), .o_data_out(dout_b),
        .i_cccr_data(cccr_data), .i_fbr_data(fbr_data), .i_cis_data(cis_data)
    );

    int          ob_done_k;
    logic [7:0]  ob_data;
    logic        ob_err;
    int          ob_stb_cnt;
    int          ob_first_stb_k;
    int          ob_last_stb_k;
    logic [16:0] ob_stb_addr;
    logic [3:0]  ob_wseq;
    logic [7:0]  ob_wdata;
    int          ob_act_cycles;
    logic [8:0]  ob_act_or;
    bit          ob_multi;
    bit          ob_busy_gap;

    task automatic run_cmd(input bit use_b, input bit w, input bit raw, input logic [2:0] f,
                           input logic [16:0] a, input logic [7:0] d);
        logic [8:0]  act;
        logic        s, wf, dn, bz, er;
        logic [16:0] ad;
        logic [7:0]  dout, cd;
        ob_done_k = -1; ob_data = 8'hxx; ob_err = 1'bx;
        ob_stb_cnt = 0; ob_first_stb_k = -1; ob_last_stb_k = -1;
        ob_stb_addr = 17'h1FFFF; ob_wseq = 4'd0; ob_wdata = 8'hxx;
        ob_act_cycles = 0; ob_act_or = 9'd0; ob_multi = 1'b0; ob_busy_gap = 1'b0;
        @(negedge clk);
        cmd_stb = 1'b1; cmd_write = w; cmd_raw = raw; cmd_func = f; cmd_addr = a; cmd_data = d;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) cmd_stb = 1'b0;
            if (use_b) begin
                act = {cis_b, fbr_b, cccr_b}; s = stb_b; wf = wf_b; dn = done_b; bz = busy_b;
                er = err_b; ad = addr_b; dout = dout_b; cd = cdata_b;
            end else begin
                act = {cis_a, fbr_a, cccr_a}; s = stb_a; wf = wf_a; dn = done_a; bz = busy_a;
                er = err_a; ad = addr_a; dout = dout_a; cd = cdata_a;
            end
            if (act != 9'd0) begin
                ob_act_cycles++;
                ob_act_or = ob_act_or | act;
                if ($countones(act) != 1) ob_multi = 1'b1;
            end
            if (s) begin
                if (ob_stb_cnt == 0) begin
                    ob_stb_addr = ad;
                    ob_first_stb_k = k;
                end
                ob_last_stb_k = k;
                ob_wseq = {ob_wseq[2:0], wf};
                if (wf) ob_wdata = dout;
                ob_stb_cnt++;
            end
            if (!bz) ob_busy_gap = 1'b1;
            if (dn) begin
                ob_done_k = k;
                ob_data = cd;
                ob_err = er;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({busy_a, done_a, err_a, cccr_a, fbr_a, cis_a, wf_a, stb_a} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0", {busy_a, done_a, err_a, cccr_a, fbr_a, cis_a, wf_a, stb_a});
        end
        n_checks++;
        if ({addr_a, cdata_a, dout_a} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {addr_a, cdata_a, dout_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cccr_read;
        repeat (8) @(negedge clk);
        cccr_data = 8'h43;
        sb.push_back('{err: 1'b0, data: 8'h43, lat: 4});
        run_cmd(1'b0, 1'b0, 1'b0, 3'd0, 17'h00000, 8'hEE);
        e = sb.pop_front();
        n_checks++;
        if (ob_done_k !== e.lat) begin n_fail++; $display("FAIL cccr_latency: got %0d expected %0d", ob_done_k, e.lat); end
        n_checks++;
        if ({ob_err, ob_data} !== {e.err, e.data}) begin n_fail++; $display("FAIL cccr_resp: got %b/%h expected %b/%h", ob_err, ob_data, e.err, e.data); end
        n_checks++;
        if ({ob_act_or, ob_act_cycles, ob_multi} !== {9'h001, 32'd2, 1'b0}) begin
            n_fail++; $display("FAIL cccr_activate: got %b x%0d expected 000000001 x2", ob_act_or, ob_act_cycles);
        end
        n_checks++;
        if ({ob_stb_cnt, ob_stb_addr, ob_wseq[0]} !== {32'd1, 17'h00000, 1'b0}) begin
            n_fail++; $display("FAIL cccr_stb: got cnt %0d addr %h wr %b expected 1/00000/0", ob_stb_cnt, ob_stb_addr, ob_wseq[0]);
        end
        n_checks++;
        if (ob_busy_gap !== 1'b0) begin n_fail++; $display("FAIL cccr_busy: got gap expected continuous busy"); end
    endtask

    task automatic test_fbr_write;
        repeat (8) @(negedge clk);
        sb.push_back('{err: 1'b0, data: 8'h00, lat: 3});
        run_cmd(1'b0, 1'b1, 1'b0, 3'd0, 17'h00110, 8'h00);
        e = sb.pop_front();
        n_checks++;
        if (ob_done_k !== e.lat) begin n_fail++; $display("FAIL fbrw_latency: got %0d expected %0d", ob_done_k, e.lat); end
        n_checks++;
        if ({ob_err, ob_data} !== {e.err, e.data}) begin n_fail++; $display("FAIL fbrw_echo: got %b/%h expected %b/%h", ob_err, ob_data, e.err, e.data); end
        n_checks++;
        if ({ob_act_or, ob_act_cycles} !== {9'h002, 32'd1}) begin
            n_fail++; $display("FAIL fbrw_activate: got %b x%0d expected 000000010 x1", ob_act_or, ob_act_cycles);
        end
        n_checks++;
        if ({ob_stb_cnt, ob_stb_addr, ob_wseq[0], ob_wdata} !== {32'd1, 17'h00010, 1'b1, 8'h00}) begin
            n_fail++; $display("FAIL fbrw_stb: got cnt %0d addr %h wr %b data %h expected 1/00010/1/00", ob_stb_cnt, ob_stb_addr, ob_wseq[0], ob_wdata);
        end
    endtask

    task automatic test_raw;
        logic [7:0] wvals [2] = '{8'h02, 8'h7E};
        for (int i = 0; i < 2; i++) begin
            repeat (8) @(negedge clk);
            fbr_data = {48'hA5A5A5A5A5A5, 8'h02};
            sb.push_back('{err: 1'b0, data: 8'h02, lat: 5});
            run_cmd(1'b0, 1'b1, 1'b1, 3'd0, 17'h00111, wvals[i]);
            e = sb.pop_front();
            n_checks++;
            if (ob_done_k !== e.lat) begin n_fail++; $display("FAIL raw%0d_latency: got %0d expected %0d", i, ob_done_k, e.lat); end
            n_checks++;
            if ({ob_err, ob_data} !== {e.err, e.data}) begin n_fail++; $display("FAIL raw%0d_resp: got %b/%h expected %b/%h", i, ob_err, ob_data, e.err, e.data); end
            n_checks++;
            if ({ob_stb_cnt, ob_wseq[1:0], ob_last_stb_k - ob_first_stb_k, ob_wdata} !== {32'd2, 2'b10, 32'd1, wvals[i]}) begin
                n_fail++; $display("FAIL raw%0d_stb: got cnt %0d seq %b gap %0d wdata %h expected 2/10/1/%h",
                                   i, ob_stb_cnt, ob_wseq[1:0], ob_last_stb_k - ob_first_stb_k, ob_wdata, wvals[i]);
            end
            n_checks++;
            if ({ob_act_or, ob_act_cycles} !== {9'h002, 32'd3}) begin
                n_fail++; $display("FAIL raw%0d_activate: got %b x%0d expected 000000010 x3", i, ob_act_or, ob_act_cycles);
            end
        end
    endtask

    task automatic test_errors;
        logic [2:0]  funcs [3] = '{3'd0, 3'd3, 3'd0};
        logic [16:0] addrs [3] = '{17'h00200, 17'h00010, 17'h18000};
        for (int i = 0; i < 3; i++) begin
            repeat (8) @(negedge clk);
            sb.push_back('{err: 1'b1, data: 8'h00, lat: 2});
            run_cmd(1'b0, 1'b0, 1'b0, funcs[i], addrs[i], 8'h5A);
            e = sb.pop_front();
            n_checks++;
            if (ob_done_k !== e.lat) begin n_fail++; $display("FAIL err%0d_latency: got %0d expected %0d", i, ob_done_k, e.lat); end
            n_checks++;
            if ({ob_err, ob_data} !== {e.err, e.data}) begin n_fail++; $display("FAIL err%0d_resp: got %b/%h expected %b/%h", i, ob_err, ob_data, e.err, e.data); end
            n_checks++;
            if ({ob_act_cycles, ob_stb_cnt} !== 64'd0) begin
                n_fail++; $display("FAIL err%0d_quiet: got act %0d stb %0d expected 0/0", i, ob_act_cycles, ob_stb_cnt);
            end
        end
    endtask

    task automatic test_cis_edge;
        repeat (8) @(negedge clk);
        cis_data = 8'h3C;
        sb.push_back('{err: 1'b0, data: 8'h3C, lat: 4});
        run_cmd(1'b0, 1'b0, 1'b0, 3'd0, 17'h17FFF, 8'h00);
        e = sb.pop_front();
        n_checks++;
        if ({ob_done_k, ob_err, ob_data} !== {e.lat, e.err, e.data}) begin
            n_fail++; $display("FAIL cis_last_resp: got %0d/%b/%h expected %0d/%b/%h", ob_done_k, ob_err, ob_data, e.lat, e.err, e.data);
        end
        n_checks++;
        if ({ob_act_or, ob_stb_addr} !== {9'h100, 17'h16FFF}) begin
            n_fail++; $display("FAIL cis_last_addr: got %b/%h expected 100000000/16fff", ob_act_or, ob_stb_addr);
        end
    endtask

    task automatic test_latency3;
        repeat (8) @(negedge clk);
        cis_data = 8'h21;
        sb.push_back('{err: 1'b0, data: 8'h21, lat: 6});
        run_cmd(1'b1, 1'b0, 1'b0, 3'd0, 17'h01004, 8'h00);
        e = sb.pop_front();
        n_checks++;
        if ({ob_done_k, ob_err, ob_data} !== {e.lat, e.err, e.data}) begin
            n_fail++; $display("FAIL cis_l3_resp: got %0d/%b/%h expected %0d/%b/%h", ob_done_k, ob_err, ob_data, e.lat, e.err, e.data);
        end
        n_checks++;
        if ({ob_act_or, ob_act_cycles, ob_stb_cnt, ob_stb_addr} !== {9'h100, 32'd4, 32'd1, 17'h00004}) begin
            n_fail++; $display("FAIL cis_l3_bus: got %b x%0d stb %0d addr %h expected 100000000 x4 1 00004", ob_act_or, ob_act_cycles, ob_stb_cnt, ob_stb_addr);
        end
        repeat (8) @(negedge clk);
        fbr_data = {40'd0, 8'h9A, 8'h11};
        sb.push_back('{err: 1'b0, data: 8'h9A, lat: 6});
        run_cmd(1'b1, 1'b0, 1'b0, 3'd0, 17'h00205, 8'h00);
        e = sb.pop_front();
        n_checks++;
        if ({ob_done_k, ob_err, ob_data} !== {e.lat, e.err, e.data}) begin
            n_fail++; $display("FAIL fbr2_resp: got %0d/%b/%h expected %0d/%b/%h", ob_done_k, ob_err, ob_data, e.lat, e.err, e.data);
        end
        n_checks++;
        if ({ob_act_or, ob_stb_addr, ob_multi} !== {9'h004, 17'h00005, 1'b0}) begin
            n_fail++; $display("FAIL fbr2_bus: got %b/%h multi %b expected 000000100/00005/0", ob_act_or, ob_stb_addr, ob_multi);
        end
    endtask

    task automatic test_back_to_back;
        repeat (8) @(negedge clk);
        cccr_data = 8'h5D;
        sb.push_back('{err: 1'b0, data: 8'h5D, lat: 4});
        sb.push_back('{err: 1'b0, data: 8'h99, lat: 3});
        run_cmd(1'b0, 1'b0, 1'b0, 3'd0, 17'h00007, 8'h00);
        e = sb.pop_front();
        n_checks++;
        if ({ob_done_k, ob_data} !== {e.lat, e.data}) begin
            n_fail++; $display("FAIL b2b_first: got %0d/%h expected %0d/%h", ob_done_k, ob_data, e.lat, e.data);
        end
        run_cmd(1'b0, 1'b1, 1'b0, 3'd0, 17'h00008, 8'h99);
        e = sb.pop_front();
        n_checks++;
        if ({ob_done_k, ob_data, ob_stb_addr} !== {e.lat, e.data, 17'h00008}) begin
            n_fail++; $display("FAIL b2b_second: got %0d/%h/%h expected %0d/%h/00008", ob_done_k, ob_data, ob_stb_addr, e.lat, e.data);
        end
    endtask

    task automatic test_reset_midop;
        bit saw_done;
        repeat (8) @(negedge clk);
        cccr_data = 8'h66;
        @(negedge clk);
        cmd_stb = 1'b1; cmd_write = 1'b0; cmd_raw = 1'b0; cmd_func = 3'd0; cmd_addr = 17'h00005; cmd_data = 8'h00;
        @(negedge clk);
        cmd_stb = 1'b0;
        repeat (2) @(negedge clk);
        cmd_stb = 1'b1; cmd_write = 1'b1; cmd_addr = 17'h00110; cmd_data = 8'h55;
        @(negedge clk);
        cmd_stb = 1'b0;
        n_checks++;
        if ({busy_b, cccr_b, fbr_b, stb_b, wf_b, done_b} !== {1'b1, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL midop_ignore: got busy %b cccr %b fbr %b stb %b wf %b done %b expected 1 1 0 0 0 0",
                               busy_b, cccr_b, fbr_b, stb_b, wf_b, done_b);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_b, cccr_b, fbr_b, cis_b} !== 10'd0) begin
            n_fail++; $display("FAIL midop_async: got busy %b cccr %b fbr %b cis %b expected 0", busy_b, cccr_b, fbr_b, cis_b);
        end
        n_checks++;
        if (cdata_a !== 8'h00) begin n_fail++; $display("FAIL midop_data_clear: got %h expected 00", cdata_a); end
        saw_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done_b || busy_b || cccr_b || stb_b) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midop_quiet: got activity after reset expected none"); end
        sb.push_back('{err: 1'b0, data: 8'h66, lat: 6});
        run_cmd(1'b1, 1'b0, 1'b0, 3'd0, 17'h00003, 8'h00);
        e = sb.pop_front();
        n_checks++;
        if ({ob_done_k, ob_err, ob_data, ob_stb_addr} !== {e.lat, e.err, e.data, 17'h00003}) begin
            n_fail++; $display("FAIL midop_recover: got %0d/%b/%h/%h expected %0d/%b/%h/00003",
                               ob_done_k, ob_err, ob_data, ob_stb_addr, e.lat, e.err, e.data);
        end
    endtask

    initial begin
        test_reset();
        test_cccr_read();
        test_fbr_write();
        test_raw();
        test_errors();
        test_cis_edge();
        test_latency3();
        test_back_to_back();
        test_reset_midop();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdio_cia_cmd52_router.md
Name: sdio_cia_cmd52_router

Overview:
- Sits directly upstream of the CIA register blocks: CCCR, per-function FBR instances, and the CIS ROM.
- Accepts one decoded CMD52 (IO_RW_DIRECT) request at a time from the SDIO command layer.
- Decodes the 17-bit function-0 register address and drives the target block's activate/write/address/strobe bus.
- For reads and read-after-write (RAW), waits the target's read latency, captures the read data and returns it with a done pulse for the R5 response.

Parameters:
- NUM_FUNCS, 1, number of I/O functions with an FBR instance (1-7); FBR windows above NUM_FUNCS decode as errors.
- READ_LATENCY, 1, cycles from target strobe to valid target read data (1-4).
- CIS_LAST_ADDR, 17'h17FFF, highest valid CIS address; CIS window starts at 17'h01000.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_cmd_stb  in  1  one-cycle request pulse; fields below valid on that cycle
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_raw  in  1  read-after-write flag; ignored when i_cmd_write = 0
- i_cmd_func  in  3  CMD52 function number
- i_cmd_addr  in  17  CMD52 register address
- i_cmd_data  in  8  write data
- o_cmd_busy  out  1  request in progress
- o_cmd_done  out  1  one-cycle completion pulse
- o_cmd_err  out  1  out-of-range flag, valid with o_cmd_done
- o_cmd_data  out  8  response data, valid with o_cmd_done and held until next accept
- o_cccr_activate  out  1  CCCR selected
- o_fbr_activate  out  7  bit n-1 selects the FBR of function n
- o_cis_activate  out  1  CIS selected
- o_write_flag  out  1  target write qualifier
- o_address  out  17  target address; FBR/CCCR use [7:0], CIS uses full offset
- o_data_stb  out  1  one-cycle target access strobe
- o_data_out  out  8  target write data
- i_cccr_data  in  8  CCCR read data
- i_fbr_data  in  56  FBR read data, byte n-1 = function n
- i_cis_data  in  8  CIS read data

Behaviour:
- Reset (async, rst_n low): FSM to IDLE; all outputs 0.
- Decode, only when i_cmd_func = 0:
  - addr 0x00000-0x000FF: CCCR, o_address = addr.
  - addr 0x00n00-0x00nFF, n = 1..NUM_FUNCS: FBR n, o_address = addr[7:0].
  - addr 0x01000-CIS_LAST_ADDR: CIS, o_address = addr - 0x01000.
  - Anything else, including any func != 0: error.
- States: IDLE, DECODE, WRITE, READ, WAIT, DONE.
- IDLE: i_cmd_stb latches all request fields, goes to DECODE, sets o_cmd_busy. i_cmd_stb while busy is ignored, with no effect on the current operation.
- DECODE (1 cycle): registers the target select and address.
  - Error target: DONE with err = 1, data = 0x00.
  - Write: WRITE.
  - Read: READ.
- WRITE: o_data_stb = 1, o_write_flag = 1, o_data_out = latched data.
  - RAW: READ.
  - Otherwise: DONE with data = written byte (echo).
- READ: o_data_stb = 1, o_write_flag = 0; then WAIT.
- WAIT: counts READ_LATENCY cycles. On the last WAIT cycle, captures the selected target's read byte into o_cmd_data; then DONE.
- Activate timing: the selected activate bit is high from WRITE/READ entry through the last WAIT cycle, and low in IDLE, DECODE and DONE. Only one activate bit is high at any time.
- DONE (1 cycle): o_cmd_done = 1, o_cmd_err as decided; next IDLE. o_cmd_busy clears the same cycle DONE is exited. A new request is accepted at the earliest the cycle after DONE.
- Latency from the stb cycle to the done pulse, READ_LATENCY = 1:
  - Error: 2 cycles.
  - Plain write: 3 cycles.
  - Read: 4 cycles.
  - RAW: 5 cycles.
- o_data_stb is never high for more than one consecutive cycle, except RAW (WRITE then READ back-to-back).
- Reset mid-operation aborts immediately with no done pulse. Outputs remain 0 until a new request is accepted after rst_n rises.

Test Plan:
- Read CCCR 0x00000, func 0; i_cccr_data = 0x43 -> o_cccr_activate high 2 cycles; single read stb with o_address = 0x00; done 4 cycles after stb, data = 0x43, err = 0.
- Write FBR1 0x00110 data 0x00, RAW = 0 -> o_fbr_activate = 7'b0000001; one write stb, o_address = 0x10; done at +3, data echoes 0x00.
- RAW write FBR1 0x00111 data 0x02; i_fbr_data[7:0] = 0x02 after the write -> write stb then read stb on consecutive cycles; done at +5, data = 0x02.
- Read 0x00200 with NUM_FUNCS = 1, and separately func = 3 any address -> no activate/stb; done at +2, err = 1, data = 0x00.
- Read CIS 0x01004; i_cis_data = 0x21; READ_LATENCY = 3 -> o_cis_activate high, o_address = 0x00004; done 6 cycles after stb, data = 0x21.
- i_cmd_stb issued during WAIT, then rst_n pulsed low mid-read -> extra stb ignored; reset clears busy and activate asynchronously, no done pulse; next request completes normally.
